// File: rtl/neureka_multi_engine_dispatch.sv
`default_nettype none
// ============================================================================
// Module  : neureka_multi_engine_dispatch
// Brief   : Job FIFO feeding N engines (lowest idle first) with clear/start/run
//           sequencing, per-job core event routing and global busy/idle events.
// Rev     : 1.0 - initial release
// ============================================================================
module neureka_multi_engine_dispatch #(
  parameter int N_ENGINES   = 2,
  parameter int N_CORES     = 8,
  parameter int N_EVT       = 2,
  parameter int QUEUE_DEPTH = 4,
  parameter int ID_WIDTH    = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             clear_i,
  input  logic                             job_valid_i,
  output logic                             job_ready_o,
  input  logic [ID_WIDTH-1:0]              job_id_i,
  input  logic [$clog2(N_CORES)-1:0]       job_core_i,
  output logic [N_ENGINES-1:0]             engine_clear_o,
  output logic [N_ENGINES-1:0]             engine_start_o,
  output logic [N_ENGINES-1:0]             engine_enable_o,
  input  logic [N_ENGINES-1:0]             engine_done_i,
  output logic                             done_valid_o,
  output logic [ID_WIDTH-1:0]              done_id_o,
  output logic [N_CORES*N_EVT-1:0]         evt_o,
  output logic                             busy_o,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0] queue_count_o
);

  localparam int c_CORE_W = $clog2(N_CORES);
  localparam int c_PTR_W  = $clog2(QUEUE_DEPTH);
  localparam int c_CNT_W  = $clog2(QUEUE_DEPTH+1);
  localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(QUEUE_DEPTH-1);
  localparam logic [c_CNT_W-1:0] c_DEPTH    = c_CNT_W'(QUEUE_DEPTH);

  // The clear phase is the dispatch cycle itself (IDLE + grant), so no
  // registered CLEAR state is needed to meet the push->clear->start timing.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2
  } eng_state_e;

  logic [ID_WIDTH-1:0]  r_fifo_id   [QUEUE_DEPTH];
  logic [c_CORE_W-1:0]  r_fifo_core [QUEUE_DEPTH];
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_CNT_W-1:0]   r_count;

  eng_state_e           r_state     [N_ENGINES];
  eng_state_e           w_state_nxt [N_ENGINES];
  logic [ID_WIDTH-1:0]  r_slot_id   [N_ENGINES];
  logic [c_CORE_W-1:0]  r_slot_core [N_ENGINES];

  logic [N_ENGINES-1:0] w_idle;
  logic [N_ENGINES-1:0] w_grant;
  logic [N_ENGINES-1:0] w_done_run;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_busy;
  logic [ID_WIDTH-1:0]  w_done_id;
  logic [N_CORES-1:0]   w_evt_done;

  logic [N_CORES-1:0]   r_evt_done;
  logic                 r_done_valid;
  logic [ID_WIDTH-1:0]  r_done_id;
  logic                 r_evt_idle;
  logic                 r_busy_q;

  function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
    return (p == c_PTR_LAST) ? '0 : p + c_PTR_W'(1);
  endfunction

  always_comb begin
    w_idle     = '0;
    w_done_run = '0;
    for (int e = 0; e < N_ENGINES; e++) begin
      w_idle[e]     = (r_state[e] == S_IDLE);
      w_done_run[e] = engine_done_i[e] && (r_state[e] == S_RUN);
    end
  end

  assign job_ready_o = (r_count < c_DEPTH);
  assign w_busy      = (r_count != '0) || !(&w_idle);
  assign w_push      = job_valid_i && job_ready_o && !clear_i;
  assign w_pop       = (r_count != '0) && (|w_idle) && !clear_i;
  // Isolate the lowest set bit of the idle mask.
  assign w_grant     = w_pop ? (w_idle & (~w_idle + N_ENGINES'(1))) : '0;

  always_comb begin
    for (int e = 0; e < N_ENGINES; e++) begin
      w_state_nxt[e] = r_state[e];
      case (r_state[e])
        S_IDLE:  if (w_grant[e]) w_state_nxt[e] = S_START;
        S_START: w_state_nxt[e] = S_RUN;
        S_RUN:   if (engine_done_i[e]) w_state_nxt[e] = S_IDLE;
        default: w_state_nxt[e] = S_IDLE;
      endcase
      if (clear_i) w_state_nxt[e] = S_IDLE;
    end
  end

  // Descending scan so the lowest-index completing engine wins the ID.
  always_comb begin
    w_done_id  = '0;
    w_evt_done = '0;
    for (int e = N_ENGINES-1; e >= 0; e--) begin
      if (w_done_run[e]) begin
        w_done_id                  = r_slot_id[e];
        w_evt_done[r_slot_core[e]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo_id[r_wr_ptr]   <= job_id_i;
      r_fifo_core[r_wr_ptr] <= job_core_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int e = 0; e < N_ENGINES; e++) begin
        r_state[e]     <= S_IDLE;
        r_slot_id[e]   <= '0;
        r_slot_core[e] <= '0;
      end
    end else begin
      for (int e = 0; e < N_ENGINES; e++) begin
        r_state[e] <= w_state_nxt[e];
        if (w_grant[e]) begin
          r_slot_id[e]   <= r_fifo_id[r_rd_ptr];
          r_slot_core[e] <= r_fifo_core[r_rd_ptr];
        end
      end
    end
  end

  // Clearing the busy history suppresses the all-idle event after a soft clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_done_valid <= 1'b0;
      r_done_id    <= '0;
      r_evt_done   <= '0;
      r_evt_idle   <= 1'b0;
      r_busy_q     <= 1'b0;
    end else if (clear_i) begin
      r_done_valid <= 1'b0;
      r_done_id    <= '0;
      r_evt_done   <= '0;
      r_evt_idle   <= 1'b0;
      r_busy_q     <= 1'b0;
    end else begin
      r_done_valid <= |w_done_run;
      r_done_id    <= w_done_id;
      r_evt_done   <= w_evt_done;
      r_evt_idle   <= r_busy_q && !w_busy;
      r_busy_q     <= w_busy;
    end
  end

  assign engine_clear_o = {N_ENGINES{clear_i}} | w_grant;
  assign done_valid_o   = r_done_valid && !clear_i;
  assign done_id_o      = clear_i ? '0 : r_done_id;
  assign busy_o         = w_busy;
  assign queue_count_o  = r_count;

  for (genvar e = 0; e < N_ENGINES; e++) begin : g_eng
    assign engine_start_o[e]  = (r_state[e] == S_START) && !clear_i;
    assign engine_enable_o[e] = (r_state[e] != S_IDLE) && !clear_i;
  end

  for (genvar c = 0; c < N_CORES; c++) begin : g_core
    for (genvar k = 0; k < N_EVT; k++) begin : g_evt
      if (k == 0) begin : g_done
        assign evt_o[c*N_EVT+k] = r_evt_done[c] && !clear_i;
      end else if (k == 1) begin : g_idle
        assign evt_o[c*N_EVT+k] = r_evt_idle && !clear_i;
      end else begin : g_tie
        assign evt_o[c*N_EVT+k] = 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_neureka_multi_engine_dispatch.sv
`default_nettype none
// ============================================================================
// Module  : tb_neureka_multi_engine_dispatch
// Brief   : Directed scenarios plus randomized run against a queue-based model.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_neureka_multi_engine_dispatch;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        clear_i;
  logic        job_valid_i;
  logic        job_ready_o;
  logic [7:0]  job_id_i;
  logic [2:0]  job_core_i;
  logic [1:0]  engine_clear_o;
  logic [1:0]  engine_start_o;
  logic [1:0]  engine_enable_o;
  logic [1:0]  engine_done_i;
  logic        done_valid_o;
  logic [7:0]  done_id_o;
  logic [15:0] evt_o;
  logic        busy_o;
  logic [2:0]  queue_count_o;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [15:0] IDLE_EVT = 16'hAAAA;

  neureka_multi_engine_dispatch dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .clear_i         (clear_i),
    .job_valid_i     (job_valid_i),
    .job_ready_o     (job_ready_o),
    .job_id_i        (job_id_i),
    .job_core_i      (job_core_i),
    .engine_clear_o  (engine_clear_o),
    .engine_start_o  (engine_start_o),
    .engine_enable_o (engine_enable_o),
    .engine_done_i   (engine_done_i),
    .done_valid_o    (done_valid_o),
    .done_id_o       (done_id_o),
    .evt_o           (evt_o),
    .busy_o          (busy_o),
    .queue_count_o   (queue_count_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- reference model (queue of jobs + engine slots) --------
  typedef struct packed { logic [7:0] id; logic [2:0] core; } job_t;
  job_t       mq[$];
  bit         m_busy [2];
  int         m_age  [2];
  logic [7:0] m_id   [2];
  logic [2:0] m_core [2];
  bit         p_dv;
  logic [7:0] p_did;
  logic [7:0] p_evt0;
  bit         p_idle;
  bit         m_prev_busy;

  logic        e_ready, e_busy, e_dv;
  logic [2:0]  e_count;
  logic [1:0]  e_clr, e_start, e_en;
  logic [15:0] e_evt;

  function automatic int m_free_eng();
    for (int e = 0; e < 2; e++) if (!m_busy[e]) return e;
    return -1;
  endfunction

  task automatic model_reset();
    mq.delete();
    for (int e = 0; e < 2; e++) begin m_busy[e] = 0; m_age[e] = 0; end
    p_dv = 0; p_did = '0; p_evt0 = '0; p_idle = 0; m_prev_busy = 0;
  endtask

  task automatic model_eval();
    int fe;
    fe      = m_free_eng();
    e_count = 3'(mq.size());
    e_ready = mq.size() < 4;
    e_busy  = (mq.size() != 0) || m_busy[0] || m_busy[1];
    e_clr   = '0;
    if (clear_i) e_clr = 2'b11;
    else if (mq.size() > 0 && fe >= 0) e_clr[fe] = 1'b1;
    for (int e = 0; e < 2; e++) begin
      e_en[e]    = !clear_i && m_busy[e];
      e_start[e] = !clear_i && m_busy[e] && (m_age[e] == 1);
    end
    e_dv  = !clear_i && p_dv;
    e_evt = '0;
    if (!clear_i)
      for (int c = 0; c < 8; c++) begin
        e_evt[2*c]   = p_evt0[c];
        e_evt[2*c+1] = p_idle;
      end
  endtask

  task automatic model_commit();
    int   fe;
    bit   busy_now, can_push;
    job_t j;
    if (clear_i) begin
      model_reset();
      return;
    end
    fe       = m_free_eng();
    busy_now = (mq.size() != 0) || m_busy[0] || m_busy[1];
    can_push = mq.size() < 4;
    p_dv = 0; p_did = '0; p_evt0 = '0;
    for (int e = 0; e < 2; e++) begin
      if (m_busy[e]) begin
        if (m_age[e] >= 2 && engine_done_i[e]) begin
          if (!p_dv) begin p_dv = 1; p_did = m_id[e]; end
          p_evt0[m_core[e]] = 1'b1;
          m_busy[e] = 0;
        end else begin
          m_age[e]++;
        end
      end
    end
    p_idle      = m_prev_busy && !busy_now;
    m_prev_busy = busy_now;
    if (fe >= 0 && mq.size() > 0) begin
      j = mq.pop_front();
      m_busy[fe] = 1; m_age[fe] = 1; m_id[fe] = j.id; m_core[fe] = j.core;
    end
    if (job_valid_i && can_push) begin
      j.id = job_id_i; j.core = job_core_i;
      mq.push_back(j);
    end
  endtask

  // ---------------- stimulus helpers --------------------------------------
  task automatic idle_in();
    clear_i = 0; job_valid_i = 0; job_id_i = '0; job_core_i = '0; engine_done_i = '0;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    idle_in();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  // ---------------- scenarios ---------------------------------------------
  task automatic test_reset();
    idle_in();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    n_cmp++;
    if ({job_ready_o, busy_o, done_valid_o, queue_count_o} !== 6'b100000) begin
      n_err++;
      $display("FAIL reset_status: got %b want 100000", {job_ready_o, busy_o, done_valid_o, queue_count_o});
    end
    n_cmp++;
    if ({engine_clear_o, engine_start_o, engine_enable_o, evt_o, done_id_o} !== 30'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want 0", {engine_clear_o, engine_start_o, engine_enable_o, evt_o, done_id_o});
    end
    step();
    rst_ni = 1'b1;
  endtask

  task automatic test_single_job();
    do_reset();
    job_valid_i = 1; job_id_i = 8'h11; job_core_i = 3'd3;          // cycle T
    @(negedge clk_i);
    n_cmp++;
    if ({job_ready_o, engine_clear_o} !== 3'b100) begin
      n_err++; $display("FAIL s1_accept: got %b want 100", {job_ready_o, engine_clear_o});
    end
    step(); job_valid_i = 0;                                          // T+1
    @(negedge clk_i);
    n_cmp++;
    if ({engine_clear_o, engine_start_o, engine_enable_o, queue_count_o, busy_o} !== 10'b01_00_00_001_1) begin
      n_err++; $display("FAIL s1_clear: got %b want 0100000011", {engine_clear_o, engine_start_o, engine_enable_o, queue_count_o, busy_o});
    end
    step();                                                           // T+2
    @(negedge clk_i);
    n_cmp++;
    if ({engine_clear_o, engine_start_o, engine_enable_o, queue_count_o} !== 9'b00_01_01_000) begin
      n_err++; $display("FAIL s1_start: got %b want 000101000", {engine_clear_o, engine_start_o, engine_enable_o, queue_count_o});
    end
    for (int i = 3; i <= 9; i++) begin
      step();
      @(negedge clk_i);
      n_cmp++;
      if ({engine_clear_o, engine_start_o, engine_enable_o, done_valid_o} !== 7'b00_00_01_0) begin
        n_err++; $display("FAIL s1_run T+%0d: got %b want 0000010", i, {engine_clear_o, engine_start_o, engine_enable_o, done_valid_o});
      end
    end
    step(); engine_done_i = 2'b01;                                    // T+10
    @(negedge clk_i);
    n_cmp++;
    if ({engine_enable_o, busy_o, evt_o} !== {2'b01, 1'b1, 16'h0000}) begin
      n_err++; $display("FAIL s1_done_cycle: got en=%b busy=%b evt=%h want en=01 busy=1 evt=0000", engine_enable_o, busy_o, evt_o);
    end
    step(); engine_done_i = 2'b00;                                    // T+11
    @(negedge clk_i);
    n_cmp++;
    if ({done_valid_o, done_id_o, evt_o, busy_o, engine_enable_o} !== {1'b1, 8'h11, 16'h0040, 1'b0, 2'b00}) begin
      n_err++; $display("FAIL s1_complete: got dv=%b id=%h evt=%h busy=%b en=%b want dv=1 id=11 evt=0040 busy=0 en=00",
                        done_valid_o, done_id_o, evt_o, busy_o, engine_enable_o);
    end
    step();                                                           // T+12
    @(negedge clk_i);
    n_cmp++;
    if ({done_valid_o, evt_o} !== {1'b0, IDLE_EVT}) begin
      n_err++; $display("FAIL s1_all_idle: got dv=%b evt=%h want dv=0 evt=aaaa", done_valid_o, evt_o);
    end
    step();                                                           // T+13
    @(negedge clk_i);
    n_cmp++;
    if (evt_o !== 16'h0000) begin
      n_err++; $display("FAIL s1_evt_quiet: got %h want 0000", evt_o);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    job_valid_i = 1;
    for (int k = 0; k < 6; k++) begin                                 // P0..P5
      job_id_i = 8'(8'h21 + k); job_core_i = 3'(k);
      step();
    end
    job_id_i = 8'h27; job_core_i = 3'd6;                              // P6: 7th held
    @(negedge clk_i);
    n_cmp++;
    if ({queue_count_o, job_ready_o, engine_enable_o} !== {3'd4, 1'b0, 2'b11}) begin
      n_err++; $display("FAIL b2b_full: got cnt=%0d rdy=%b en=%b want cnt=4 rdy=0 en=11", queue_count_o, job_ready_o, engine_enable_o);
    end
    step();                                                           // P7
    @(negedge clk_i);
    n_cmp++;
    if ({queue_count_o, job_ready_o} !== {3'd4, 1'b0}) begin
      n_err++; $display("FAIL b2b_hold: got cnt=%0d rdy=%b want cnt=4 rdy=0", queue_count_o, job_ready_o);
    end
    step(); engine_done_i = 2'b10;                                    // P8 = D
    step(); engine_done_i = 2'b00;                                    // P9 = D+1
    @(negedge clk_i);
    n_cmp++;
    if ({engine_clear_o, done_valid_o, done_id_o, evt_o, job_ready_o} !== {2'b10, 1'b1, 8'h22, 16'h0004, 1'b0}) begin
      n_err++; $display("FAIL b2b_redispatch: got clr=%b dv=%b id=%h evt=%h rdy=%b want clr=10 dv=1 id=22 evt=0004 rdy=0",
                        engine_clear_o, done_valid_o, done_id_o, evt_o, job_ready_o);
    end
    step();                                                           // P10
    @(negedge clk_i);
    n_cmp++;
    if ({engine_start_o, queue_count_o, job_ready_o} !== {2'b10, 3'd3, 1'b1}) begin
      n_err++; $display("FAIL b2b_ready_rise: got st=%b cnt=%0d rdy=%b want st=10 cnt=3 rdy=1", engine_start_o, queue_count_o, job_ready_o);
    end
    step(); job_valid_i = 0;                                          // P11
    @(negedge clk_i);
    n_cmp++;
    if ({queue_count_o, job_ready_o} !== {3'd4, 1'b0}) begin
      n_err++; $display("FAIL b2b_held_pushed: got cnt=%0d rdy=%b want cnt=4 rdy=0", queue_count_o, job_ready_o);
    end
    step(); engine_done_i = 2'b10;                                    // P12
    step(); engine_done_i = 2'b00;                                    // P13
    @(negedge clk_i);
    n_cmp++;
    if ({done_id_o, evt_o, engine_clear_o, engine_enable_o} !== {8'h23, 16'h0010, 2'b10, 2'b01}) begin
      n_err++; $display("FAIL b2b_order: got id=%h evt=%h clr=%b en=%b want id=23 evt=0010 clr=10 en=01",
                        done_id_o, evt_o, engine_clear_o, engine_enable_o);
    end
  endtask

  task automatic test_simultaneous_done();
    do_reset();
    job_valid_i = 1; job_id_i = 8'h05; job_core_i = 3'd1;             // T
    step(); job_id_i = 8'h09;                                         // T+1
    step(); job_valid_i = 0;                                          // T+2
    @(negedge clk_i);
    n_cmp++;
    if (engine_clear_o !== 2'b10) begin
      n_err++; $display("FAIL sim_dispatch1: got %b want 10", engine_clear_o);
    end
    repeat (4) step();                                                // T+6
    engine_done_i = 2'b11;
    step(); engine_done_i = 2'b00;                                    // T+7
    @(negedge clk_i);
    n_cmp++;
    if ({done_valid_o, done_id_o, evt_o} !== {1'b1, 8'h05, 16'h0004}) begin
      n_err++; $display("FAIL sim_done: got dv=%b id=%h evt=%h want dv=1 id=05 evt=0004", done_valid_o, done_id_o, evt_o);
    end
    step();                                                           // T+8
    @(negedge clk_i);
    n_cmp++;
    if ({done_valid_o, evt_o} !== {1'b0, IDLE_EVT}) begin
      n_err++; $display("FAIL sim_idle: got dv=%b evt=%h want dv=0 evt=aaaa", done_valid_o, evt_o);
    end
  endtask

  task automatic test_ignored_done();
    do_reset();
    job_valid_i = 1; job_id_i = 8'h33; job_core_i = 3'd6;             // T
    step(); job_valid_i = 0; engine_done_i = 2'b11;                   // T+1 clear phase
    @(negedge clk_i);
    n_cmp++;
    if (engine_clear_o !== 2'b01) begin
      n_err++; $display("FAIL ign_clear: got %b want 01", engine_clear_o);
    end
    step(); engine_done_i = 2'b01;                                    // T+2 start
    @(negedge clk_i);
    n_cmp++;
    if ({engine_start_o, engine_enable_o, done_valid_o, evt_o} !== {2'b01, 2'b01, 1'b0, 16'h0000}) begin
      n_err++; $display("FAIL ign_start: got st=%b en=%b dv=%b evt=%h want st=01 en=01 dv=0 evt=0000",
                        engine_start_o, engine_enable_o, done_valid_o, evt_o);
    end
    for (int i = 3; i <= 4; i++) begin
      step(); engine_done_i = 2'b00;
      @(negedge clk_i);
      n_cmp++;
      if ({engine_enable_o, done_valid_o, evt_o} !== {2'b01, 1'b0, 16'h0000}) begin
        n_err++; $display("FAIL ign_run T+%0d: got en=%b dv=%b evt=%h want en=01 dv=0 evt=0000", i, engine_enable_o, done_valid_o, evt_o);
      end
    end
    step(); engine_done_i = 2'b01;                                    // T+5
    step(); engine_done_i = 2'b00;                                    // T+6
    @(negedge clk_i);
    n_cmp++;
    if ({done_valid_o, done_id_o, evt_o} !== {1'b1, 8'h33, 16'h1000}) begin
      n_err++; $display("FAIL ign_real_done: got dv=%b id=%h evt=%h want dv=1 id=33 evt=1000", done_valid_o, done_id_o, evt_o);
    end
  endtask

  task automatic test_soft_clear();
    do_reset();
    job_valid_i = 1;
    for (int k = 0; k < 5; k++) begin                                 // P0..P4
      job_id_i = 8'(8'h61 + k); job_core_i = 3'(k);
      step();
    end
    job_valid_i = 0;                                                  // P5
    @(negedge clk_i);
    n_cmp++;
    if ({queue_count_o, engine_enable_o} !== {3'd3, 2'b11}) begin
      n_err++; $display("FAIL clr_setup: got cnt=%0d en=%b want cnt=3 en=11", queue_count_o, engine_enable_o);
    end
    step(); clear_i = 1; job_valid_i = 1; job_id_i = 8'h77;           // P6
    @(negedge clk_i);
    n_cmp++;
    if ({engine_clear_o, engine_start_o, engine_enable_o, done_valid_o, evt_o} !== {2'b11, 2'b00, 2'b00, 1'b0, 16'h0000}) begin
      n_err++; $display("FAIL clr_cycle: got clr=%b st=%b en=%b dv=%b evt=%h want clr=11 st=00 en=00 dv=0 evt=0000",
                        engine_clear_o, engine_start_o, engine_enable_o, done_valid_o, evt_o);
    end
    step(); clear_i = 0; job_valid_i = 0;                             // P7
    @(negedge clk_i);
    n_cmp++;
    if ({queue_count_o, busy_o, engine_clear_o, engine_enable_o, job_ready_o} !== {3'd0, 1'b0, 2'b00, 2'b00, 1'b1}) begin
      n_err++; $display("FAIL clr_after: got cnt=%0d busy=%b clr=%b en=%b rdy=%b want cnt=0 busy=0 clr=00 en=00 rdy=1",
                        queue_count_o, busy_o, engine_clear_o, engine_enable_o, job_ready_o);
    end
    for (int i = 8; i <= 9; i++) begin
      step();
      @(negedge clk_i);
      n_cmp++;
      if ({evt_o, done_valid_o, engine_clear_o} !== 19'd0) begin
        n_err++; $display("FAIL clr_no_evt P%0d: got evt=%h dv=%b clr=%b want all 0", i, evt_o, done_valid_o, engine_clear_o);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    job_valid_i = 1; job_id_i = 8'h44; job_core_i = 3'd4;
    step(); job_valid_i = 0; job_id_i = 8'h66;
    job_valid_i = 1;                                                  // queue one more behind it
    step(); job_valid_i = 0;
    repeat (2) step();
    @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    n_cmp++;
    if ({job_ready_o, busy_o, done_valid_o, queue_count_o, engine_clear_o, engine_start_o, engine_enable_o, evt_o}
        !== {1'b1, 1'b0, 1'b0, 3'd0, 2'b00, 2'b00, 2'b00, 16'h0000}) begin
      n_err++; $display("FAIL arst_immediate: got rdy=%b busy=%b dv=%b cnt=%0d clr=%b st=%b en=%b evt=%h",
                        job_ready_o, busy_o, done_valid_o, queue_count_o, engine_clear_o, engine_start_o, engine_enable_o, evt_o);
    end
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    job_valid_i = 1; job_id_i = 8'h55; job_core_i = 3'd2;             // T
    step(); job_valid_i = 0;                                          // T+1
    @(negedge clk_i);
    n_cmp++;
    if ({engine_clear_o, queue_count_o} !== {2'b01, 3'd1}) begin
      n_err++; $display("FAIL arst_clear: got clr=%b cnt=%0d want clr=01 cnt=1", engine_clear_o, queue_count_o);
    end
    step();                                                           // T+2
    @(negedge clk_i);
    n_cmp++;
    if ({engine_start_o, engine_enable_o} !== 4'b0101) begin
      n_err++; $display("FAIL arst_start: got st=%b en=%b want st=01 en=01", engine_start_o, engine_enable_o);
    end
  endtask

  task automatic test_random();
    idle_in();
    rst_ni = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    for (int i = 0; i < 600; i++) begin
      job_valid_i   = ($urandom % 3) != 0;
      job_id_i      = 8'($urandom);
      job_core_i    = 3'($urandom);
      engine_done_i = {($urandom % 4) == 0, ($urandom % 4) == 0};
      clear_i       = ($urandom % 50) == 0;
      @(negedge clk_i);
      model_eval();
      n_cmp++;
      if ({job_ready_o, queue_count_o, busy_o} !== {e_ready, e_count, e_busy}) begin
        n_err++; $display("FAIL rnd_fifo cyc%0d: got rdy=%b cnt=%0d busy=%b want rdy=%b cnt=%0d busy=%b",
                          i, job_ready_o, queue_count_o, busy_o, e_ready, e_count, e_busy);
      end
      n_cmp++;
      if ({engine_clear_o, engine_start_o, engine_enable_o} !== {e_clr, e_start, e_en}) begin
        n_err++; $display("FAIL rnd_engine cyc%0d: got clr=%b st=%b en=%b want clr=%b st=%b en=%b",
                          i, engine_clear_o, engine_start_o, engine_enable_o, e_clr, e_start, e_en);
      end
      n_cmp++;
      if ({done_valid_o, evt_o} !== {e_dv, e_evt}) begin
        n_err++; $display("FAIL rnd_events cyc%0d: got dv=%b evt=%h want dv=%b evt=%h", i, done_valid_o, evt_o, e_dv, e_evt);
      end
      if (e_dv) begin
        n_cmp++;
        if (done_id_o !== p_did) begin
          n_err++; $display("FAIL rnd_done_id cyc%0d: got %h want %h", i, done_id_o, p_did);
        end
      end
      @(posedge clk_i);
      model_commit();
      #1;
    end
    idle_in();
  endtask

  initial begin
    idle_in();
    rst_ni = 1'b0;
    test_reset();
    test_single_job();
    test_back_to_back();
    test_simultaneous_done();
    test_ignored_done();
    test_soft_clear();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/neureka_multi_engine_dispatch.md
Name: neureka_multi_engine_dispatch

Overview:
Job dispatcher for the next-generation multi-engine NEUREKA cluster subsystem. It accepts job tokens from the register-file/controller side into a QUEUE_DEPTH-entry FIFO and dispatches each job to the lowest-index idle engine with a clear→start→run sequence. It gates each engine's enable, routes per-core completion events to the core that owns each job, and raises a global busy/idle indication. It generalises the single-engine enable=busy scheme to N_ENGINES engines with queued jobs and per-job event routing.

Parameters:
N_ENGINES, 2, number of engine+streamer instances served (≥1)
N_CORES, 8, number of cluster cores receiving events
N_EVT, 2, events per core (bit0 job-done, bit1 all-idle; ≥2)
QUEUE_DEPTH, 4, job FIFO entries (≥2, any integer)
ID_WIDTH, 8, job ID width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
clear_i  in  1  synchronous soft clear
job_valid_i  in  1  job token valid
job_ready_o  out  1  FIFO can accept token
job_id_i  in  ID_WIDTH  job identifier
job_core_i  in  $clog2(N_CORES)  owning core index
engine_clear_o  out  N_ENGINES  per-engine clear pulse
engine_start_o  out  N_ENGINES  per-engine start pulse
engine_enable_o  out  N_ENGINES  per-engine enable (high in START/RUN)
engine_done_i  in  N_ENGINES  per-engine done pulse
done_valid_o  out  1  a job completed this cycle
done_id_o  out  ID_WIDTH  ID of completed job (lowest-index engine)
evt_o  out  N_CORES*N_EVT  per-core event pulses [core][evt]
busy_o  out  1  any queued or running job
queue_count_o  out  $clog2(QUEUE_DEPTH+1)  FIFO occupancy

Behaviour:
- Reset: FIFO empty, all engines IDLE; all outputs 0 except job_ready_o=1.
- FIFO: push on job_valid_i&&job_ready_o; job_ready_o=(count<QUEUE_DEPTH). No bypass: a job pushed into an empty FIFO dispatches no earlier than the next cycle. Push and pop in the same cycle leaves count unchanged. Pointers wrap modulo QUEUE_DEPTH.
- Dispatch: when the FIFO is non-empty and ≥1 engine is IDLE, pop the head and assign it to the lowest-index IDLE engine. At most one dispatch per cycle. The engine latches {id, core} in its slot.
- Per-engine FSM: IDLE→CLEAR (engine_clear_o=1 for 1 cycle)→START (engine_start_o=1, enable=1 for 1 cycle)→RUN (enable=1)→IDLE on engine_done_i.
- engine_done_i is ignored outside RUN. Done arriving in the START cycle is also ignored.
- Latency: accept at cycle T → clear at T+1 → start at T+2 → enable from T+2 onward.
- Completion: in the done cycle the engine returns to IDLE. The next cycle it is eligible for dispatch, so clear occurs at done+1 at the earliest.
- Registered, 1-cycle outputs in the cycle after done:
  - evt_o[core][0] pulse.
  - done_valid_o=1 with done_id_o from the lowest-index completing engine.
- Simultaneous completions: all owning cores get bit0, ORed if they share a core. Only the lowest-index ID is reported.
- busy_o = (count≠0) | any engine ≠IDLE.
- On a busy_o 1→0 transition, evt_o[*][1] pulses for 1 cycle on all cores, in the cycle after busy_o falls.
- evt bits ≥2 are tied 0.
- clear_i (synchronous, priority over everything):
  - FIFO flushed and all engines forced IDLE.
  - engine_clear_o all 1 for that cycle; start/enable/evt/done_valid all 0.
  - A push in the same cycle is dropped.
  - No all-idle event is generated.
- Asynchronous reset mid-operation returns all state and outputs to reset values immediately.

Test Plan:
- Reset, then push id=0x11 core=3 at T → engine0 clear@T+1, start@T+2, enable@T+2; done@T+10 → evt[3][0] and done_valid with id 0x11 @T+11, busy_o=0 @T+11, evt[*][1] @T+12.
- Push 6 jobs back-to-back with N_ENGINES=2, QUEUE_DEPTH=4 and engines never done → 2 dispatched, count=4, job_ready_o=0, the 7th valid is held. Done engine1 → next job goes to engine1 at done+1 clear; ready rises once a slot pops.
- Both engines done the same cycle with ids 0x05 (eng0, core1) and 0x09 (eng1, core1) → evt[1][0] single pulse, done_id_o=0x05.
- Done pulse during CLEAR/START and while IDLE → ignored; FSM and events unchanged.
- clear_i asserted with 3 queued and 2 running plus a push in the same cycle → count=0, engines IDLE, engine_clear_o=2'b11 for 1 cycle, no evt, busy_o=0 next cycle.
- rst_ni asserted low mid-RUN → all outputs at reset values asynchronously; the first push after release behaves as in scenario 1.
